// File: rtl/sram_drain_burst_sched_pkg.sv
// Shared definitions for the SRAM-drain burst scheduler: FSM state encoding
// and the AXI burst-length helpers used on the write-address channel.
package sram_drain_burst_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_HOLD,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    // AXI4 AxLEN field width and the width of the transfer beat counter.
    localparam int AXI_LEN_W    = 8;
    localparam int XFER_BEATS_W = 32;

    // AxLEN encodes beats-1.
    function automatic logic [AXI_LEN_W-1:0] axi_len(input logic [AXI_LEN_W-1:0] beats);
        return beats - 8'd1;
    endfunction

endpackage

// File: rtl/sram_drain_burst_sched.sv
// Moves a transfer of xfer_beats beats from an upstream SRAM unit to an AXI
// write port, one burst at a time. Each burst is first reserved upstream
// (drain_req/drain_size), then announced on AW, then streamed through W.
module sram_drain_burst_sched
    import sram_drain_burst_sched_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int SEG_COUNT_WIDTH = 10,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_BURST       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       xfer_start,
    input  logic [ADDR_WIDTH-1:0]      xfer_addr,
    input  logic [XFER_BEATS_W-1:0]    xfer_beats,
    input  logic [7:0]                 cfg_burst_len,
    input  logic [SEG_COUNT_WIDTH-1:0] data_avail,
    output logic                       drain_req,
    output logic [7:0]                 drain_size,
    input  logic                       sram_valid,
    output logic                       sram_ready,
    input  logic [DATA_WIDTH-1:0]      sram_data,
    output logic                       aw_valid,
    input  logic                       aw_ready,
    output logic [ADDR_WIDTH-1:0]      aw_addr,
    output logic [AXI_LEN_W-1:0]       aw_len,
    output logic                       w_valid,
    input  logic                       w_ready,
    output logic [DATA_WIDTH-1:0]      w_data,
    output logic                       w_last,
    output logic                       busy,
    output logic                       done
);

    localparam int          BEAT_BYTES  = DATA_WIDTH / 8;
    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;       // address of the next burst
    logic [31:0]             remaining_q;  // beats not yet written
    logic [7:0]              eff_len_q;    // clamped configured burst length
    logic [AXI_LEN_W-1:0]    len_q;        // current burst length minus one
    logic [7:0]              beat_cnt_q;   // beat index within current burst

    logic [7:0]              eff_len;
    logic [31:0]             burst;
    logic [31:0]             burst_beats;
    logic [31:0]             rem_after;
    logic [ADDR_WIDTH-1:0]   burst_bytes;
    logic                    avail_ok;
    logic                    w_hs;
    logic                    last_beat;

    // Zero asks for single beats; anything above MAX_BURST is clamped.
    assign eff_len = (cfg_burst_len == 8'd0)                 ? 8'd1 :
                     ({24'd0, cfg_burst_len} > MAX_BURST_W)  ? MAX_BURST_W[7:0] :
                                                               cfg_burst_len;

    // The final burst of a transfer may be shorter than the configured length.
    assign burst       = (remaining_q < {24'd0, eff_len_q}) ? remaining_q : {24'd0, eff_len_q};
    assign avail_ok    = 32'(data_avail) >= burst;

    assign burst_beats = 32'(len_q) + 32'd1;
    assign rem_after   = remaining_q - burst_beats;
    assign burst_bytes = ADDR_WIDTH'(burst_beats) * ADDR_WIDTH'(BEAT_BYTES);

    assign last_beat   = (beat_cnt_q == len_q);
    assign w_hs        = (state == S_DATA) && sram_valid && w_ready;

    assign aw_addr     = addr_q;
    assign aw_len      = len_q;
    assign w_data      = sram_data;
    assign busy        = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment uses <= so all registers update
        // from the same pre-edge values regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output and the next state get a default first, so no
        // path through the case statement can infer a latch.
        state_next = state;
        drain_req  = 1'b0;
        drain_size = 8'd0;
        aw_valid   = 1'b0;
        sram_ready = 1'b0;
        w_valid    = 1'b0;
        w_last     = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer_start)
                    state_next = (xfer_beats == '0) ? S_DONE : S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (avail_ok) begin
                    drain_req  = 1'b1;
                    drain_size = burst[7:0];
                    state_next = S_HOLD;
                end
            end
            // data_avail still reflects the pre-reservation count here.
            S_HOLD: state_next = S_ADDR;
            S_ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) state_next = S_DATA;
            end
            S_DATA: begin
                w_valid    = sram_valid;
                sram_ready = w_ready;
                w_last     = last_beat;
                if (w_hs && last_beat)
                    state_next = (rem_after == 32'd0) ? S_DONE : S_WAIT_DATA;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: latch on start, size each burst, advance on w_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            eff_len_q   <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer_start) begin
                        addr_q      <= xfer_addr;
                        remaining_q <= xfer_beats;
                        eff_len_q   <= eff_len;
                    end
                end
                S_WAIT_DATA: begin
                    if (avail_ok) begin
                        len_q      <= axi_len(burst[7:0]);
                        beat_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            remaining_q <= rem_after;
                            addr_q      <= addr_q + burst_bytes;
                            beat_cnt_q  <= '0;
                        end else begin
                            beat_cnt_q  <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_drain_burst_sched.sv
// Self-checking bench for sram_drain_burst_sched: directed scenarios plus
// randomized transfers, scored against a burst-list reference model and an
// upstream SRAM model that supplies the reserved beats.
module tb_sram_drain_burst_sched;

    localparam int DW   = 512;
    localparam int SEGW = 10;
    localparam int AW   = 64;
    localparam int MAXB = 16;

    logic            clk;
    logic            rst;
    logic            xfer_start;
    logic [AW-1:0]   xfer_addr;
    logic [31:0]     xfer_beats;
    logic [7:0]      cfg_burst_len;
    logic [SEGW-1:0] data_avail;
    logic            drain_req;
    logic [7:0]      drain_size;
    logic            sram_valid;
    logic            sram_ready;
    logic [DW-1:0]   sram_data;
    logic            aw_valid;
    logic            aw_ready;
    logic [AW-1:0]   aw_addr;
    logic [7:0]      aw_len;
    logic            w_valid;
    logic            w_ready;
    logic [DW-1:0]   w_data;
    logic            w_last;
    logic            busy;
    logic            done;

    sram_drain_burst_sched #(
        .DATA_WIDTH(DW), .SEG_COUNT_WIDTH(SEGW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .xfer_start(xfer_start), .xfer_addr(xfer_addr), .xfer_beats(xfer_beats),
        .cfg_burst_len(cfg_burst_len), .data_avail(data_avail),
        .drain_req(drain_req), .drain_size(drain_size),
        .sram_valid(sram_valid), .sram_ready(sram_ready), .sram_data(sram_data),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          size;
        logic [63:0] addr;
    } burst_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model state.
    burst_t        exp_drain_q[$];
    burst_t        exp_aw_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] sram_q[$];
    bit outstanding, in_data, xfer_active;
    int cur_size, beat_idx;
    int drain_count, aw_count, beats_total, last_count, done_count;
    int first_drain_cycle, done_cycle;

    // Environment knobs.
    int avail;
    bit avail_consume;
    int avail_raise_at, avail_raise_to;
    int aw_mode, w_mode, aw_low_left;
    bit sv_gaps, spur_start, sv_hold, w_toggle;

    bit            aw_stalled_prev, w_stalled_prev;
    logic [AW-1:0] prev_aw_addr;
    logic [7:0]    prev_aw_len;
    logic [DW-1:0] prev_w_data;
    logic          prev_w_last;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Observe one cycle's outputs and advance the model by the handshakes
    // that the coming clock edge will complete.
    task automatic monitor();
        if (aw_stalled_prev) begin
            check("aw_valid_held", aw_valid, 1'b1);
            check("aw_addr_held", aw_addr, prev_aw_addr);
            check("aw_len_held", aw_len, prev_aw_len);
        end
        if (w_stalled_prev) begin
            check("w_valid_held", w_valid, 1'b1);
            check("w_data_held", w_data, prev_w_data);
            check("w_last_held", w_last, prev_w_last);
        end

        check("sram_ready", sram_ready, in_data && w_ready);
        check("w_valid", w_valid, in_data && sram_valid);
        if (!in_data) check("w_last_outside", w_last, 1'b0);
        if (aw_valid) check("aw_after_drain", outstanding && !in_data, 1'b1);

        if (drain_req) begin
            check("drain_outstanding", outstanding, 1'b0);
            check("drain_avail", 32'(data_avail) >= 32'(drain_size), 1'b1);
            check("drain_expected", exp_drain_q.size() > 0, 1'b1);
            if (exp_drain_q.size() > 0) begin
                burst_t b = exp_drain_q.pop_front();
                check("drain_size", drain_size, b.size);
            end
            if (drain_count == 0) first_drain_cycle = cycle;
            drain_count++;
            outstanding = 1'b1;
            if (avail_consume) avail -= int'(drain_size);
            for (int k = 0; k < int'(drain_size); k++) begin
                logic [DW-1:0] d = rand_beat();
                sram_q.push_back(d);
                exp_data_q.push_back(d);
            end
        end

        if (aw_valid && aw_ready) begin
            check("aw_expected", exp_aw_q.size() > 0, 1'b1);
            if (exp_aw_q.size() > 0) begin
                burst_t b = exp_aw_q.pop_front();
                check("aw_addr", aw_addr, b.addr);
                check("aw_len", aw_len, b.size - 1);
                cur_size = b.size;
            end
            aw_count++;
            in_data  = 1'b1;
            beat_idx = 0;
        end
        if (aw_valid && !aw_ready && aw_low_left > 0) aw_low_left--;

        if (sram_valid && sram_ready && sram_q.size() > 0) void'(sram_q.pop_front());
        if (w_valid && w_ready) begin
            check("w_data_expected", exp_data_q.size() > 0, 1'b1);
            if (exp_data_q.size() > 0) check("w_data", w_data, exp_data_q.pop_front());
            check("w_last", w_last, beat_idx == cur_size - 1);
            beat_idx++;
            beats_total++;
            if (w_last) begin
                last_count++;
                in_data     = 1'b0;
                outstanding = 1'b0;
            end
        end

        if (done) begin
            check("done_busy", busy, 1'b1);
            done_count++;
            done_cycle  = cycle;
            xfer_active = 1'b0;
        end

        aw_stalled_prev = aw_valid && !aw_ready;
        prev_aw_addr    = aw_addr;
        prev_aw_len     = aw_len;
        w_stalled_prev  = w_valid && !w_ready;
        prev_w_data     = w_data;
        prev_w_last     = w_last;
        sv_hold         = sram_valid && !sram_ready;
    endtask

    task automatic drive();
        xfer_start = 1'b0;
        if (spur_start && xfer_active && $urandom_range(0, 7) == 0) begin
            xfer_start    = 1'b1;
            xfer_addr     = {$urandom, $urandom};
            xfer_beats    = $urandom_range(0, 60);
            cfg_burst_len = 8'($urandom);
        end
        case (aw_mode)
            0:       aw_ready = 1'b1;
            1:       aw_ready = 1'($urandom_range(0, 1));
            default: aw_ready = (aw_low_left == 0);
        endcase
        case (w_mode)
            0:       w_ready = 1'b1;
            1:       w_ready = 1'($urandom_range(0, 1));
            default: begin
                w_toggle = ~w_toggle;
                w_ready  = w_toggle;
            end
        endcase
        sram_valid = (sram_q.size() > 0) && (sv_hold || !sv_gaps || $urandom_range(0, 3) != 0);
        sram_data  = (sram_q.size() > 0) ? sram_q[0] : '0;
        if (avail_raise_at >= 0 && cycle >= avail_raise_at) avail = avail_raise_to;
        if (avail_consume && $urandom_range(0, 3) == 0 && avail < 1000) avail += $urandom_range(0, 6);
        data_avail = SEGW'(avail);
    endtask

    // One clock: sample at the falling edge, drive just after the rising edge.
    task automatic step();
        @(negedge clk);
        cycle++;
        if (!rst) monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic flush_model();
        exp_drain_q.delete();
        exp_aw_q.delete();
        exp_data_q.delete();
        sram_q.delete();
        outstanding     = 1'b0;
        in_data         = 1'b0;
        xfer_active     = 1'b0;
        aw_stalled_prev = 1'b0;
        w_stalled_prev  = 1'b0;
        sv_hold         = 1'b0;
        sram_valid      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_drain_req"}, drain_req, 1'b0);
        check({tag, "_drain_size"}, drain_size, 8'd0);
        check({tag, "_aw_valid"}, aw_valid, 1'b0);
        check({tag, "_aw_addr"}, aw_addr, '0);
        check({tag, "_aw_len"}, aw_len, 8'd0);
        check({tag, "_w_valid"}, w_valid, 1'b0);
        check({tag, "_w_last"}, w_last, 1'b0);
        check({tag, "_sram_ready"}, sram_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // Burst list derived directly from the transfer rules.
    task automatic plan_xfer(input logic [63:0] addr, input int beats, input int cfg);
        int eff = (cfg == 0) ? 1 : (cfg > MAXB) ? MAXB : cfg;
        int rem = beats;
        logic [63:0] a = addr;
        while (rem > 0) begin
            burst_t b;
            b.size = (rem < eff) ? rem : eff;
            b.addr = a;
            exp_drain_q.push_back(b);
            exp_aw_q.push_back(b);
            a   = a + 64'(b.size * (DW / 8));
            rem = rem - b.size;
        end
        drain_count = 0; aw_count = 0; beats_total = 0; last_count = 0; done_count = 0;
        first_drain_cycle = -1; done_cycle = -1;
    endtask

    task automatic start_xfer(input logic [63:0] addr, input int beats, input int cfg);
        xfer_addr     = addr;
        xfer_beats    = beats;
        cfg_burst_len = 8'(cfg);
        xfer_start    = 1'b1;
        xfer_active   = 1'b1;
    endtask

    task automatic run_xfer(input string tag, input logic [63:0] addr, input int beats,
                            input int cfg, output int latency);
        int nb, start_cycle;
        plan_xfer(addr, beats, cfg);
        nb = exp_drain_q.size();
        start_cycle = cycle;
        start_xfer(addr, beats, cfg);
        step();
        for (int n = 0; n < 4000 && done_count == 0; n++) step();
        check({tag, "_done_seen"}, done_count, 1);
        latency = done_cycle - start_cycle;
        xfer_active = 1'b0;
        step();
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_done_pulses"}, done_count, 1);
        check({tag, "_beats"}, beats_total, beats);
        check({tag, "_drains"}, drain_count, nb);
        check({tag, "_aws"}, aw_count, nb);
        check({tag, "_lasts"}, last_count, nb);
        check({tag, "_left"}, exp_drain_q.size() + exp_aw_q.size() + exp_data_q.size(), 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; xfer_start = 1'b0; xfer_addr = '0; xfer_beats = '0; cfg_burst_len = '0;
        data_avail = '0; sram_valid = 1'b0; sram_data = '0; aw_ready = 1'b0; w_ready = 1'b0;
        avail = 0; avail_consume = 0; avail_raise_at = -1; avail_raise_to = 0;
        aw_mode = 0; w_mode = 0; aw_low_left = 0; sv_gaps = 0; spur_start = 0; w_toggle = 0;
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // 40 beats in bursts of 16 with plenty of data and no back-pressure.
        avail = 64;
        drive();
        run_xfer("b40", 64'h1000, 40, 16, lat);

        // Reservation waits until data_avail covers the burst.
        avail = 5;
        avail_raise_at = cycle + 20;
        avail_raise_to = 8;
        drive();
        run_xfer("wait", 64'h0, 8, 8, lat);
        check("wait_first_drain", first_drain_cycle >= avail_raise_at, 1'b1);
        avail_raise_at = -1;

        // Empty transfer completes straight away.
        avail = 64;
        run_xfer("zero", 64'h8000, 0, 5, lat);
        check("zero_latency", lat, 2);

        // Long AW stall followed by alternating W back-pressure.
        aw_mode = 2; aw_low_left = 7; w_mode = 2;
        run_xfer("stall", 64'h2000, 20, 8, lat);
        aw_mode = 0; w_mode = 0;

        // Burst length of zero and an oversized one.
        run_xfer("len0", 64'h3000, 3, 0, lat);
        run_xfer("len200", 64'h4000, 20, 200, lat);

        // Address wrap at the top of the address space.
        run_xfer("wrap", 64'hFFFF_FFFF_FFFF_FC00, 40, 16, lat);

        // Reset in the middle of a 16-beat burst, then a clean transfer.
        plan_xfer(64'h6000, 16, 16);
        start_xfer(64'h6000, 16, 16);
        step();
        for (int n = 0; n < 500 && beats_total < 5; n++) step();
        check("mid_beat5", beats_total, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        flush_model();
        rst = 1'b0;
        drive();
        run_xfer("after_rst", 64'h5000, 16, 16, lat);

        // Randomized transfers with stalls, data gaps and ignored start pulses.
        aw_mode = 1; w_mode = 1; sv_gaps = 1; spur_start = 1; avail_consume = 1;
        for (int t = 0; t < 12; t++) begin
            logic [63:0] a;
            int b, c;
            a = {$urandom, $urandom} & ~64'(DW / 8 - 1);
            if (t % 4 == 3) a = 64'hFFFF_FFFF_FFFF_FFC0;
            b = $urandom_range(1, 48);
            case ($urandom_range(0, 3))
                0:       c = 0;
                1:       c = $urandom_range(17, 255);
                default: c = $urandom_range(1, 16);
            endcase
            avail = $urandom_range(0, 20);
            run_xfer($sformatf("rnd%0d", t), a, b, c, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
